osc_freq_meter: RTL and testbench

OSC_FREQ_METER -- requirements
Module: osc_freq_meter

---
 rtl/osc_freq_meter.sv | 152 +++++++++++++++
 tb/tb_osc_freq_meter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/osc_freq_meter.sv
// Oscillator frequency meter: counts synchronized rising edges of osc_in over a gate window.
// Build option: define OSC_FREQ_SAT_EN to saturate the counter and raise ovf instead of wrapping.
module osc_freq_meter #(
  parameter int CNT_W  = 20,
  parameter int GATE_W = 16,
  parameter int SETTLE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              osc_in,
  output logic              osc_en,
  output logic              busy,
  output logic [CNT_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              ovf
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_GATE, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q, hist_q;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d, ovf_inc;
  logic              valid_q, valid_d;
  logic              osc_en_q, osc_en_d;
  logic              busy_q, busy_d;
  logic              edge_det;

  assign edge_det = sync2_q & ~hist_q;

  // Counter step for this cycle; ovf_inc only ever rises in the saturating build.
  always_comb begin
    cnt_inc = cnt_q;
    ovf_inc = ovf_q;
    if (edge_det) begin
`ifdef OSC_FREQ_SAT_EN
      if (&cnt_q) ovf_inc = 1'b1;
      else        cnt_inc = cnt_q + CNT_ONE;
`else
      cnt_inc = cnt_q + CNT_ONE;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    gate_d   = gate_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    osc_en_d = osc_en_q;
    busy_d   = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SETTLE;
          gate_d   = gate_cycles;
          settle_d = '0;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          osc_en_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_q == SET_LAST) begin
          if (gate_q == '0) begin
            state_d  = S_HOLD;
            result_d = cnt_q;
            valid_d  = 1'b1;
            osc_en_d = 1'b0;
          end else begin
            state_d = S_GATE;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_GATE: begin
        cnt_d = cnt_inc;
        ovf_d = ovf_inc;
        // The edge seen on the final gate cycle still belongs to this window.
        if (gate_q == GATE_ONE) begin
          state_d  = S_HOLD;
          result_d = cnt_inc;
          valid_d  = 1'b1;
          osc_en_d = 1'b0;
        end else begin
          gate_d = gate_q - GATE_ONE;
        end
      end
      S_HOLD: begin
        if (result_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      hist_q   <= 1'b0;
      settle_q <= '0;
      gate_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      osc_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= osc_in;
      sync2_q  <= sync1_q;
      hist_q   <= sync2_q;
      settle_q <= settle_d;
      gate_q   <= gate_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      osc_en_q <= osc_en_d;
      busy_q   <= busy_d;
    end
  end

  assign osc_en       = osc_en_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Directed bench for osc_freq_meter: a default-width instance plus a CNT_W=4 instance for wrap/saturation.
module tb_osc_freq_meter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] gate_cycles = '0;
  logic        osc_in = 1'b0;
  logic        result_ready = 1'b0;

  logic        osc_en_a, busy_a, valid_a, ovf_a;
  logic [19:0] result_a;
  logic        osc_en_b, busy_b, valid_b, ovf_b;
  logic [3:0]  result_b;

  int errors = 0;
  int checks = 0;

  osc_freq_meter #(.CNT_W(20), .GATE_W(16), .SETTLE(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_cycles(gate_cycles), .osc_in(osc_in),
    .osc_en(osc_en_a), .busy(busy_a), .result(result_a), .result_valid(valid_a),
    .result_ready(result_ready), .ovf(ovf_a));

  osc_freq_meter #(.CNT_W(4), .GATE_W(16), .SETTLE(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_cycles(gate_cycles), .osc_in(osc_in),
    .osc_en(osc_en_b), .busy(busy_b), .result(result_b), .result_valid(valid_b),
    .result_ready(result_ready), .ovf(ovf_b));

  always #5 clk = ~clk;

  // clk/4 square wave, changing on falling clk edges
  always begin
    @(negedge clk);
    @(negedge clk);
    osc_in = ~osc_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] g);
    @(negedge clk);
    start = 1'b1;
    gate_cycles = g;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycles after the accepting edge until result_valid, and cycles with osc_en high meanwhile.
  task automatic wait_valid(output int lat, output int en);
    lat = 0;
    en  = 0;
    while (!valid_a && lat < 500) begin
      if (osc_en_a) en++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    result_ready = 1'b1;
    @(posedge clk);
    #1 result_ready = 1'b0;
    chk({tag, "_valid_low"}, valid_a, 0);
    chk({tag, "_busy_low"}, busy_a, 0);
  endtask

  initial begin
    int lat, en, vcnt;
    logic [19:0] r0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_osc_en", osc_en_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_result", result_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_valid_b", valid_b, 0);
    @(negedge clk) rst_n = 1'b1;

    // gate=100 on clk/4: 25 edges, valid 108 edges after accept
    do_start(16'd100);
    chk("t1_osc_en_k1", osc_en_a, 1);
    chk("t1_busy", busy_a, 1);
    wait_valid(lat, en);
    chk("t1_latency", lat, 108);
    chk("t1_osc_en_cycles", en, 108);
    chk("t1_osc_en_off", osc_en_a, 0);
    chk("t1_result_in_24_26", (result_a >= 24 && result_a <= 26), 1);
    chk("t1_ovf", ovf_a, 0);
`ifdef OSC_FREQ_SAT_EN
    chk("t1b_result_sat", result_b, 15);
    chk("t1b_ovf_sat", ovf_b, 1);
`else
    chk("t1b_result_wrap_8_10", (result_b >= 8 && result_b <= 10), 1);
    chk("t1b_ovf_wrap", ovf_b, 0);
`endif

    // Hold with ready low for 10 cycles; start during the hold is ignored
    r0 = result_a;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      @(posedge clk);
      #1;
      chk("t3_hold_valid", valid_a, 1);
      chk("t3_hold_ovf", ovf_a, 0);
      chk("t3_hold_osc_en", osc_en_a, 0);
    end
    chk("t3_hold_result_stable", result_a, r0);
    start = 1'b1;
    handshake("t3");
    start = 1'b0;
    @(posedge clk);
    #1 chk("t3_start_at_handshake_ignored", busy_a, 0);

    // gate=0: straight from settle to hold
    do_start(16'd0);
    wait_valid(lat, en);
    chk("t2_latency", lat, 8);
    chk("t2_osc_en_cycles", en, 8);
    chk("t2_result", result_a, 0);
    chk("t2_ovf", ovf_a, 0);
    chk("t2b_result", result_b, 0);
    handshake("t2");

    // start pulses during SETTLE and GATE are ignored
    do_start(16'd20);
    for (int i = 0; i < 28; i++) begin
      start = (i == 3 || i == 15);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("t4_valid_at_28", valid_a, 1);
    chk("t4_result_in_4_6", (result_a >= 4 && result_a <= 6), 1);
    handshake("t4");
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (valid_a || busy_a) vcnt++;
    end
    chk("t4_single_result", vcnt, 0);

    // reset mid-GATE, then a fresh measurement
    do_start(16'd100);
    repeat (30) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_rst_osc_en", osc_en_a, 0);
    chk("t5_rst_busy", busy_a, 0);
    chk("t5_rst_result", result_a, 0);
    chk("t5_rst_valid", valid_a, 0);
    chk("t5_rst_ovf", ovf_a, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("t5_no_partial_valid", valid_a, 0);
    do_start(16'd100);
    wait_valid(lat, en);
    chk("t5_latency", lat, 108);
    chk("t5_result_in_24_26", (result_a >= 24 && result_a <= 26), 1);
    handshake("t5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
